kiwi_handle_store: RTL and testbench

KIWI_HANDLE_STORE -- requirements
Module: kiwi_handle_store

---
 rtl/kiwi_hs_pkg.sv | 56 +++++
 rtl/kiwi_hs_obj_bank.sv | 65 ++++++
 rtl/kiwi_handle_store.sv | 234 +++++++++++++++++++++++
 tb/tb_kiwi_handle_store.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/kiwi_hs_pkg.sv
// kiwi_hs_pkg -- shared definitions for the kiwi handle store.
//   * opcode and field encodings carried on cmd_op / cmd_field
//   * FSM state encoding
//   * reset-value functions for every object field
package kiwi_hs_pkg;

    // Opcodes (cmd_op). Codes 5..7 are illegal.
    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SWAP  = 3'd3;
    localparam logic [2:0] OP_BIND  = 3'd4;

    // Field selectors (cmd_field).
    localparam logic [1:0] FLD_LEFT  = 2'd0;
    localparam logic [1:0] FLD_RIGHT = 2'd1;
    localparam logic [1:0] FLD_ARROW = 2'd2;
    localparam logic [1:0] FLD_RP    = 2'd3;

    // Storage slot layout inside one object: LEFT, RIGHT, ARROW, then RP[0..].
    localparam int SLOT_RP0 = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_EXEC    = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    function automatic int unsigned left_rst(input int unsigned obj);
        return 10 * obj + 22;
    endfunction

    function automatic int unsigned right_rst(input int unsigned obj);
        return 10 * obj + 23;
    endfunction

    function automatic int unsigned rp_rst(input int unsigned obj, input int unsigned k,
                                           input int unsigned depth);
        return 1001 + obj * depth + k;
    endfunction

    // Reset value of a storage slot, slot numbering as in SLOT_RP0 above.
    function automatic int unsigned entry_rst(input int unsigned obj, input int unsigned slot,
                                              input int unsigned depth);
        if (slot == 0)
            return left_rst(obj);
        else if (slot == 1)
            return right_rst(obj);
        else if (slot == 2)
            return obj;
        else
            return rp_rst(obj, slot - SLOT_RP0, depth);
    endfunction

endpackage

// File: rtl/kiwi_hs_obj_bank.sv
// kiwi_hs_obj_bank -- flop storage for NUM_OBJ heap objects, each holding
// LEFT, RIGHT, ARROW and RP[0..RP_DEPTH-1].
// Ports:
//   clk, reset          clock, synchronous active-low reset (restores reset values)
//   rd_obj, rd_slot     combinational read address; out-of-range reads return 0
//   rd_data             read data
//   wr_en, wr_obj,      write port, applied on the rising edge;
//   wr_slot, wr_data    out-of-range writes are dropped
module kiwi_hs_obj_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_OBJ  = 2,
    parameter int RP_DEPTH = 2,
    parameter int OBJ_W    = 1,
    parameter int SLOT_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OBJ_W-1:0]  rd_obj,
    input  logic [SLOT_W-1:0] rd_slot,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [OBJ_W-1:0]  wr_obj,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [DATA_W-1:0] wr_data
);
    import kiwi_hs_pkg::*;

    localparam int NSLOT = SLOT_RP0 + RP_DEPTH;
    localparam int NENT  = NUM_OBJ * NSLOT;

    logic [DATA_W-1:0] mem [NENT];

    int  rd_flat;
    int  wr_flat;
    logic rd_ok;
    logic wr_ok;

    assign rd_ok   = (int'(rd_obj) < NUM_OBJ) && (int'(rd_slot) < NSLOT);
    assign wr_ok   = (int'(wr_obj) < NUM_OBJ) && (int'(wr_slot) < NSLOT);
    assign rd_flat = int'(rd_obj) * NSLOT + int'(rd_slot);
    assign wr_flat = int'(wr_obj) * NSLOT + int'(wr_slot);

    // Mux over all entries so an unmapped address can never produce X.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NENT; i++) begin
            if (rd_ok && (rd_flat == i))
                rd_data = mem[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NENT; gi++) begin : g_ent
            localparam int unsigned RST_VAL = entry_rst(gi / NSLOT, gi % NSLOT, RP_DEPTH);
            always_ff @(posedge clk) begin
                if (!reset)
                    mem[gi] <= DATA_W'(RST_VAL);
                else if (wr_en && wr_ok && (wr_flat == gi))
                    mem[gi] <= wr_data;
            end
        end
    endgenerate

endmodule

// File: rtl/kiwi_handle_store.sv
// kiwi_handle_store -- handle-indirected object store.
// A command is accepted in IDLE, the handle is mapped to an object in
// RESOLVE, all state changes happen on the EXEC edge, and RESP emits a
// one-cycle response carrying the post-update value.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   cmd_valid / cmd_ready      command handshake (ready only in IDLE)
//   cmd_op, cmd_h, cmd_field,  operation, handle, field, RP index,
//   cmd_idx, cmd_data          operand / SWAP partner / BIND object
//   rsp_valid, rsp_data,       one-cycle response, data and error flag
//   rsp_err
module kiwi_handle_store #(
    parameter int DATA_W   = 32,
    parameter int NUM_OBJ  = 2,
    parameter int RP_DEPTH = 2,
    parameter int NUM_H    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [$clog2(NUM_H)-1:0]      cmd_h,
    input  logic [1:0]                    cmd_field,
    // One value wider than the largest legal index, so an out-of-range
    // RP index can actually be presented and flagged.
    input  logic [$clog2(RP_DEPTH+1)-1:0] cmd_idx,
    input  logic [DATA_W-1:0]             cmd_data,
    output logic                          rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          rsp_err
);
    import kiwi_hs_pkg::*;

    localparam int H_W    = $clog2(NUM_H);
    localparam int IDX_W  = $clog2(RP_DEPTH + 1);
    localparam int OBJ_W  = $clog2(NUM_OBJ);
    localparam int SLOT_W = $clog2(SLOT_RP0 + RP_DEPTH);

    state_t state_reg, state_next;

    logic [2:0]        op_reg;
    logic [H_W-1:0]    h_reg;
    logic [1:0]        field_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [DATA_W-1:0] data_reg;
    logic [OBJ_W-1:0]  obj_reg;
    logic              err_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic              rsp_err_reg;

    logic [OBJ_W-1:0]  handle_reg [NUM_H];

    logic [OBJ_W-1:0]  h_val;
    logic [OBJ_W-1:0]  p_val;
    logic              h_ok;
    logic              p_ok;
    logic              err_calc;
    logic [SLOT_W-1:0] slot;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              exec_ok;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_next = ST_RESOLVE;
            end
            ST_RESOLVE: state_next = ST_EXEC;
            ST_EXEC:    state_next = ST_RESP;
            ST_RESP: begin
                rsp_valid  = 1'b1;
                state_next = ST_IDLE;
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    // Handle lookups for the selected handle and the SWAP partner. The
    // *_ok flags double as the "selector in range" checks.
    always_comb begin
        h_val = '0;
        p_val = '0;
        h_ok  = 1'b0;
        p_ok  = 1'b0;
        for (int i = 0; i < NUM_H; i++) begin
            if (int'(h_reg) == i) begin
                h_val = handle_reg[i];
                h_ok  = 1'b1;
            end
            if (data_reg == DATA_W'(i)) begin
                p_val = handle_reg[i];
                p_ok  = 1'b1;
            end
        end
    end

    always_comb begin
        err_calc = !h_ok;
        case (op_reg)
            OP_READ, OP_WRITE, OP_ADD: begin
                if (int'(h_val) >= NUM_OBJ)
                    err_calc = 1'b1;
                if ((field_reg == FLD_RP) && (int'(idx_reg) >= RP_DEPTH))
                    err_calc = 1'b1;
            end
            OP_SWAP: begin
                if (!p_ok)
                    err_calc = 1'b1;
            end
            OP_BIND: begin
                if (data_reg >= DATA_W'(NUM_OBJ))
                    err_calc = 1'b1;
            end
            default: err_calc = 1'b1;
        endcase
    end

    // ---------------- object datapath ----------------
    always_comb begin
        if (field_reg == FLD_RP)
            slot = SLOT_W'(SLOT_RP0 + int'(idx_reg));
        else
            slot = SLOT_W'(field_reg);
    end

    assign exec_ok = (state_reg == ST_EXEC) && !err_reg;
    assign sum     = rd_data + data_reg;   // wraps modulo 2^DATA_W
    assign wr_en   = exec_ok && ((op_reg == OP_WRITE) || (op_reg == OP_ADD));
    assign wr_data = (op_reg == OP_ADD) ? sum : data_reg;

    // Value the response carries; equals the field's post-update contents.
    always_comb begin
        case (op_reg)
            OP_READ:  result = rd_data;
            OP_WRITE: result = data_reg;
            OP_ADD:   result = sum;
            OP_BIND:  result = data_reg;
            default:  result = '0;
        endcase
    end

    kiwi_hs_obj_bank #(
        .DATA_W   (DATA_W),
        .NUM_OBJ  (NUM_OBJ),
        .RP_DEPTH (RP_DEPTH),
        .OBJ_W    (OBJ_W),
        .SLOT_W   (SLOT_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .rd_obj  (obj_reg),
        .rd_slot (slot),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_obj  (obj_reg),
        .wr_slot (slot),
        .wr_data (wr_data)
    );

    // ---------------- handle registers ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_H; gi++) begin : g_handle
            always_ff @(posedge clk) begin
                if (!reset) begin
                    handle_reg[gi] <= OBJ_W'(gi % NUM_OBJ);
                end else if (exec_ok) begin
                    // A self-swap takes the first branch and writes back
                    // its own value, so it is naturally a no-op.
                    if (op_reg == OP_SWAP) begin
                        if (int'(h_reg) == gi)
                            handle_reg[gi] <= p_val;
                        else if (data_reg == DATA_W'(gi))
                            handle_reg[gi] <= h_val;
                    end else if ((op_reg == OP_BIND) && (int'(h_reg) == gi)) begin
                        handle_reg[gi] <= OBJ_W'(data_reg);
                    end
                end
            end
        end
    endgenerate

    // ---------------- command capture and response ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_reg       <= '0;
            h_reg        <= '0;
            field_reg    <= '0;
            idx_reg      <= '0;
            data_reg     <= '0;
            obj_reg      <= '0;
            err_reg      <= 1'b0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            if ((state_reg == ST_IDLE) && cmd_valid) begin
                op_reg    <= cmd_op;
                h_reg     <= cmd_h;
                field_reg <= cmd_field;
                idx_reg   <= cmd_idx;
                data_reg  <= cmd_data;
            end
            if (state_reg == ST_RESOLVE) begin
                obj_reg <= h_val;
                err_reg <= err_calc;
            end
            if (state_reg == ST_EXEC) begin
                rsp_data_reg <= err_reg ? '0 : result;
                rsp_err_reg  <= err_reg;
            end
        end
    end

    assign rsp_data = rsp_data_reg;
    assign rsp_err  = rsp_err_reg;

endmodule

// File: tb/tb_kiwi_handle_store.sv
module tb_kiwi_handle_store;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [0:0]  cmd_h;
    logic [1:0]  cmd_field;
    logic [1:0]  cmd_idx;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    kiwi_handle_store #(
        .DATA_W   (32),
        .NUM_OBJ  (2),
        .RP_DEPTH (2),
        .NUM_H    (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_h     (cmd_h),
        .cmd_field (cmd_field),
        .cmd_idx   (cmd_idx),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one command from a negedge, then check latency, busy, data, error
    // and that the response pulse is exactly one cycle wide.
    task automatic tx(input string tag, input logic [2:0] op, input int h,
                      input logic [1:0] f, input int idx, input logic [31:0] d,
                      input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] rd;
        logic        re;
        logic        rdy;
        int          n;
        cmd_op    = op;
        cmd_h     = h[0:0];
        cmd_field = f;
        cmd_idx   = idx[1:0];
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
        end
        rd  = rsp_data;
        re  = rsp_err;
        rdy = cmd_ready;
        $display("tx %s op=%0d h=%0d f=%0d i=%0d d=%0h -> data=%0h err=%0b lat=%0d",
                 tag, op, h, f, idx, d, rd, re, n);
        chk({tag, ".lat"}, n, 3);
        chk({tag, ".busy"}, rdy, 0);
        chk({tag, ".data"}, rd, exp_d);
        chk({tag, ".err"}, re, exp_e);
        @(negedge clk);
        chk({tag, ".pulse"}, rsp_valid, 0);
    endtask

    initial begin
        int seen;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_h     = '0;
        cmd_field = '0;
        cmd_idx   = '0;
        cmd_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst.ready", cmd_ready, 1);
        chk("rst.valid", rsp_valid, 0);
        chk("rst.data",  rsp_data, 0);
        chk("rst.err",   rsp_err, 0);
        reset = 1'b1;
        @(negedge clk);

        // op: 0 READ 1 WRITE 2 ADD 3 SWAP 4 BIND ; field: 0 L 1 R 2 A 3 RP
        tx("rd_h0_left",   3'd0, 0, 2'd0, 0, 32'd0, 32'd22, 1'b0);
        tx("rd_h1_left",   3'd0, 1, 2'd0, 0, 32'd0, 32'd32, 1'b0);
        tx("rd_h1_arrow",  3'd0, 1, 2'd2, 0, 32'd0, 32'd1,  1'b0);
        tx("swap1",        3'd3, 0, 2'd0, 0, 32'd1, 32'd0,  1'b0);
        tx("rd_h0_rp1",    3'd0, 0, 2'd3, 1, 32'd0, 32'd1004, 1'b0);
        tx("swap_back",    3'd3, 0, 2'd0, 0, 32'd1, 32'd0,  1'b0);
        for (int i = 0; i < 4; i++)
            tx("swap_loop", 3'd3, 0, 2'd0, 0, 32'd1, 32'd0, 1'b0);
        tx("rd_h0_left4",  3'd0, 0, 2'd0, 0, 32'd0, 32'd22, 1'b0);

        tx("add_h1_rp0",   3'd2, 1, 2'd3, 0, 32'd100000, 32'd101003, 1'b0);
        tx("wr_h1_rp1",    3'd1, 1, 2'd3, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        tx("add_wrap",     3'd2, 1, 2'd3, 1, 32'd2, 32'd1, 1'b0);
        tx("rd_wrap",      3'd0, 1, 2'd3, 1, 32'd0, 32'd1, 1'b0);

        tx("bind_h1_0",    3'd4, 1, 2'd0, 0, 32'd0, 32'd0, 1'b0);
        tx("wr_h0_right",  3'd1, 0, 2'd1, 0, 32'd7, 32'd7, 1'b0);
        tx("rd_h1_right",  3'd0, 1, 2'd1, 0, 32'd0, 32'd7, 1'b0);

        tx("bind_bad",     3'd4, 1, 2'd0, 0, 32'd5, 32'd0, 1'b1);
        tx("rd_h1_after",  3'd0, 1, 2'd0, 0, 32'd0, 32'd22, 1'b0);
        tx("idx_bad",      3'd0, 0, 2'd3, 3, 32'd0, 32'd0, 1'b1);
        tx("op_bad",       3'd6, 0, 2'd0, 0, 32'd0, 32'd0, 1'b1);
        tx("swap_bad",     3'd3, 0, 2'd0, 0, 32'd2, 32'd0, 1'b1);
        tx("swap_self",    3'd3, 0, 2'd0, 0, 32'd0, 32'd0, 1'b0);
        tx("rd_h0_self",   3'd0, 0, 2'd0, 0, 32'd0, 32'd22, 1'b0);
        tx("bind_h1_1",    3'd4, 1, 2'd0, 0, 32'd1, 32'd1, 1'b0);
        tx("rd_h1_arrow2", 3'd0, 1, 2'd2, 0, 32'd0, 32'd1, 1'b0);

        // WRITE abandoned by a reset pulse during its EXEC cycle (T+2).
        cmd_op    = 3'd1;
        cmd_h     = 1'b0;
        cmd_field = 2'd0;
        cmd_idx   = 2'd0;
        cmd_data  = 32'd555;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        $display("tx rst_mid write h0 left 555 abandoned");
        chk("rst_mid.valid", rsp_valid, 0);
        chk("rst_mid.ready", cmd_ready, 1);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("rst_mid.nopulse", seen, 0);
        tx("rd_after_rst",  3'd0, 0, 2'd0, 0, 32'd0, 32'd22, 1'b0);
        tx("rd_h1_rst",     3'd0, 1, 2'd1, 0, 32'd0, 32'd33, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
